// File: rtl/tm1638_pkg.sv
// Shared constants, FSM encodings and helpers for the TM1638 write-only transmitter.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON   = 8'h88;
  localparam logic [7:0] CMD_DISP_OFF  = 8'h80;

  localparam int BYTE_CNT_W = 5;
  localparam int BIT_CNT_W  = 3;
  localparam int FRAME_W    = 2;

  // F2 carries the address command plus 16 data bytes.
  localparam logic [BYTE_CNT_W-1:0] F2_BYTES = 5'd17;

  localparam logic [FRAME_W-1:0] FRAME_F1 = 2'd0;
  localparam logic [FRAME_W-1:0] FRAME_F2 = 2'd1;
  localparam logic [FRAME_W-1:0] FRAME_F3 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STB_LEAD  = 3'd1,
    ST_BIT_LO    = 3'd2,
    ST_BIT_HI    = 3'd3,
    ST_STB_TRAIL = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } tm_state_e;

  typedef enum logic [1:0] {
    SH_IDLE = 2'd0,
    SH_LO   = 2'd1,
    SH_HI   = 2'd2
  } sh_phase_e;

  function automatic logic [7:0] disp_cmd(input logic on, input logic [2:0] bright);
    return on ? (CMD_DISP_ON | {5'd0, bright}) : CMD_DISP_OFF;
  endfunction

endpackage

// File: rtl/tm1638_byte_shift.sv
// Serialises one byte LSB first as sclk-low / sclk-high pairs, advancing only on tick enables.
module tm1638_byte_shift
  import tm1638_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_release,
  output logic       o_sclk,
  output logic       o_dio,
  output logic       o_byte_done,
  output sh_phase_e  o_phase
);

  sh_phase_e            r_phase;
  logic [7:0]           r_sr;
  logic [BIT_CNT_W-1:0] r_bit;
  logic                 r_sclk;
  logic                 r_dio;

  // Combinational so the sequencer can chain the next load onto the same tick.
  assign o_byte_done = i_tick && (r_phase == SH_HI) && (r_bit == 3'd7);
  assign o_sclk      = r_sclk;
  assign o_dio       = r_dio;
  assign o_phase     = r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= SH_IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b1;
      r_dio   <= 1'b1;
    end else if (i_load) begin
      r_sr    <= i_data;
      r_dio   <= i_data[0];
      r_sclk  <= 1'b0;
      r_bit   <= '0;
      r_phase <= SH_LO;
    end else if (i_release) begin
      r_dio <= 1'b1;
    end else if (i_tick) begin
      case (r_phase)
        SH_LO: begin
          r_sclk  <= 1'b1;
          r_phase <= SH_HI;
        end
        SH_HI: begin
          if (r_bit == 3'd7) begin
            r_phase <= SH_IDLE;
          end else begin
            r_sr    <= {1'b0, r_sr[7:1]};
            r_dio   <= r_sr[1];
            r_sclk  <= 1'b0;
            r_bit   <= r_bit + 3'd1;
            r_phase <= SH_LO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tm1638_tx.sv
// TM1638 refresh transmitter: snapshots the display state and sends the three-frame write sequence.
// Define TM1638_LED_EN to drive LED bytes from led[]; otherwise odd addresses always carry 0x00.
module tm1638_tx
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        upd_req,
  input  logic [63:0] seg,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  input  logic        disp_on,
  output logic        busy,
  output logic        done,
  output logic        stb,
  output logic        sclk,
  output logic        dio,
  output logic [4:0]  dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  tm_state_e             r_state;
  logic [DIV_W-1:0]      r_div;
  logic [FRAME_W-1:0]    r_frame;
  logic [BYTE_CNT_W-1:0] r_byte;
  logic                  r_gap;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_stb;
  logic [63:0]           r_seg;
  logic [2:0]            r_bright;
  logic                  r_disp_on;
`ifdef TM1638_LED_EN
  logic [7:0]            r_led;
`else
  logic                  w_led_unused;
  assign w_led_unused = ^led;
`endif

  logic                  w_tick;
  logic                  w_byte_done;
  logic                  w_more;
  logic                  w_load;
  logic                  w_release;
  logic                  w_sclk;
  logic                  w_dio;
  logic [BYTE_CNT_W-1:0] w_frame_len;
  logic [BYTE_CNT_W-1:0] w_next_idx;
  logic [3:0]            w_addr;
  logic [7:0]            w_byte;
  sh_phase_e             w_sh_phase;

  // Handshake: upd_req is sampled only while busy=0; acceptance raises busy on the next cycle,
  // requests during busy are dropped, and done marks the last busy cycle.
  assign busy      = r_busy;
  assign done      = r_done;
  assign stb       = r_stb;
  assign sclk      = w_sclk;
  assign dio       = w_dio;
  assign dbg_state = {w_sh_phase, r_state};

  assign w_tick      = r_busy && (r_div == DIV_LAST);
  assign w_frame_len = (r_frame == FRAME_F2) ? F2_BYTES : BYTE_CNT_W'(1);
  assign w_more      = (r_byte + BYTE_CNT_W'(1)) < w_frame_len;
  assign w_next_idx  = (r_state == ST_STB_LEAD) ? '0 : r_byte + BYTE_CNT_W'(1);
  assign w_addr      = 4'(w_next_idx - BYTE_CNT_W'(1));
  assign w_load      = w_tick && ((r_state == ST_STB_LEAD) ||
                                  ((r_state == ST_BIT_HI) && w_byte_done && w_more));
  assign w_release   = w_tick && (r_state == ST_STB_TRAIL);

  // Byte about to be loaded: even addresses are digits, odd addresses are LED bytes.
  always_comb begin
    w_byte = CMD_DATA_AUTO;
    case (r_frame)
      FRAME_F1: w_byte = CMD_DATA_AUTO;
      FRAME_F2: begin
        if (w_next_idx == '0) begin
          w_byte = CMD_ADDR0;
        end else if (!w_addr[0]) begin
          w_byte = r_seg[{w_addr[3:1], 3'b000} +: 8];
        end else begin
`ifdef TM1638_LED_EN
          w_byte = {7'd0, r_led[w_addr[3:1]]};
`else
          w_byte = 8'h00;
`endif
        end
      end
      default: w_byte = disp_cmd(r_disp_on, r_bright);
    endcase
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if ((r_state == ST_IDLE) || (r_div == DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_frame   <= FRAME_F1;
      r_byte    <= '0;
      r_gap     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stb     <= 1'b1;
      r_seg     <= '0;
      r_bright  <= '0;
      r_disp_on <= 1'b0;
`ifdef TM1638_LED_EN
      r_led     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (upd_req) begin
            r_seg     <= seg;
            r_bright  <= brightness;
            r_disp_on <= disp_on;
`ifdef TM1638_LED_EN
            r_led     <= led;
`endif
            r_busy    <= 1'b1;
            r_stb     <= 1'b0;
            r_frame   <= FRAME_F1;
            r_byte    <= '0;
            r_gap     <= 1'b0;
            r_state   <= ST_STB_LEAD;
          end
        end
        ST_STB_LEAD: begin
          if (w_tick) begin
            r_byte  <= '0;
            r_state <= ST_BIT_LO;
          end
        end
        ST_BIT_LO: begin
          if (w_tick) r_state <= ST_BIT_HI;
        end
        ST_BIT_HI: begin
          if (w_tick) begin
            if (!w_byte_done) begin
              r_state <= ST_BIT_LO;
            end else if (w_more) begin
              r_byte  <= r_byte + BYTE_CNT_W'(1);
              r_state <= ST_BIT_LO;
            end else begin
              r_state <= ST_STB_TRAIL;
            end
          end
        end
        ST_STB_TRAIL: begin
          if (w_tick) begin
            r_stb   <= 1'b1;
            r_gap   <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The final gap ends one cycle early so done lands on the last busy cycle.
          if (r_gap && (r_frame == FRAME_F3)) begin
            if (r_div == DIV_PRE) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (w_tick) begin
            if (!r_gap) begin
              r_gap <= 1'b1;
            end else begin
              r_gap   <= 1'b0;
              r_frame <= r_frame + FRAME_W'(1);
              r_stb   <= 1'b0;
              r_state <= ST_STB_LEAD;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tm1638_byte_shift u_shift (
    .clk         (clk_50M),
    .rst         (reset),
    .i_tick      (w_tick),
    .i_load      (w_load),
    .i_data      (w_byte),
    .i_release   (w_release),
    .o_sclk      (w_sclk),
    .o_dio       (w_dio),
    .o_byte_done (w_byte_done),
    .o_phase     (w_sh_phase)
  );

endmodule

// File: tb/tb_tm1638_tx.sv
// Bench for tm1638_tx: a serial-bus monitor decodes bytes and frame widths against an expected queue.
module tb_tm1638_tx;

  localparam int CLK_DIV = 4;
  localparam int SEQ_CYC = 316 * CLK_DIV;
`ifdef TM1638_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic        clk_50M = 1'b0;
  logic        reset = 1'b0;
  logic        upd_req = 1'b0;
  logic [63:0] seg = '0;
  logic [7:0]  led = '0;
  logic [2:0]  brightness = '0;
  logic        disp_on = 1'b0;
  logic        busy, done, stb, sclk, dio;
  logic [4:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int done_cnt = 0;
  int seq_bytes = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] stbw_q[$];

  tm1638_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .upd_req    (upd_req),
    .seg        (seg),
    .led        (led),
    .brightness (brightness),
    .disp_on    (disp_on),
    .busy       (busy),
    .done       (done),
    .stb        (stb),
    .sclk       (sclk),
    .dio        (dio),
    .dbg_state  (dbg_state)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [63:0] s, input logic [7:0] l, input logic [7:0] f3);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(s[8*i +: 8]);
      exp_q.push_back(LED_EN ? {7'd0, l[i]} : 8'h00);
    end
    exp_q.push_back(f3);
    stbw_q.push_back(16'((1 + 16 + 1) * CLK_DIV));
    stbw_q.push_back(16'((1 + 17 * 16 + 1) * CLK_DIV));
    stbw_q.push_back(16'((1 + 16 + 1) * CLK_DIV));
    exp_done++;
  endtask

  task automatic request(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b,
                         input logic on);
    @(negedge clk_50M);
    seg = s; led = l; brightness = b; disp_on = on;
    upd_req = 1'b1;
    seq_bytes = 0;
    @(negedge clk_50M);
    upd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk_50M);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (seq_bytes < n && k < 3000) begin
      @(negedge clk_50M);
      k++;
    end
    if (seq_bytes < n) begin
      checks++; failures++;
      $display("FAIL wait_bytes_timeout actual=%0d required=%0d", seq_bytes, n);
    end
  endtask

  // Monitor: samples pins on the falling clock edge, away from DUT updates.
  initial begin
    logic       p_sclk, p_stb, p_done;
    logic [7:0] m_sr;
    int         m_bits, stb_cnt, busy_cnt;
    p_sclk = 1'b1; p_stb = 1'b1; p_done = 1'b0;
    m_sr = '0; m_bits = 0; stb_cnt = 0; busy_cnt = 0;
    forever begin
      @(negedge clk_50M);
      if (reset) begin
        m_bits = 0; stb_cnt = 0; busy_cnt = 0;
        p_sclk = 1'b1; p_stb = 1'b1; p_done = 1'b0;
      end else begin
        if (!stb && sclk && !p_sclk) begin
          m_sr = {dio, m_sr[7:1]};
          m_bits++;
          if (m_bits % 8 == 0) begin
            seq_bytes++;
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_byte actual=0x%02h required=none", m_sr);
            end else begin
              check("byte", {24'd0, m_sr}, {24'd0, exp_q.pop_front()});
            end
          end
        end
        if (!stb) stb_cnt++;
        if (stb && !p_stb) begin
          check("frame_bits_mod8", m_bits % 8, 0);
          m_bits = 0;
          if (stbw_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame actual=%0d required=none", stb_cnt);
          end else begin
            check("stb_low_width", stb_cnt, {16'd0, stbw_q.pop_front()});
          end
          stb_cnt = 0;
        end
        if (busy) begin
          busy_cnt++;
        end else if (busy_cnt != 0) begin
          check("busy_width", busy_cnt, SEQ_CYC);
          busy_cnt = 0;
        end
        if (p_done) check("done_single_last", {30'd0, done, busy}, 0);
        if (done) begin
          done_cnt++;
          check("done_while_busy", {31'd0, busy}, 1);
        end
        p_sclk = sclk; p_stb = stb; p_done = done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked before any clock edge reaches the DUT.
    #2 reset = 1'b1;
    #1;
    check("reset_stb", {31'd0, stb}, 1);
    check("reset_sclk", {31'd0, sclk}, 1);
    check("reset_dio", {31'd0, dio}, 1);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
    repeat (4) @(negedge clk_50M);
    check("idle_dbg_state", {27'd0, dbg_state}, 0);
    check("idle_pins", {28'd0, stb, sclk, dio, busy}, 4'b1110);

    // Full refresh, display on at max brightness.
    push_expected(64'h3F06_5B4F_666D_7D07, 8'hA5, 8'h8F);
    request(64'h3F06_5B4F_666D_7D07, 8'hA5, 3'd7, 1'b1);
    check("busy_after_accept", {31'd0, busy}, 1);
    wait_idle();

    // Display off overrides brightness.
    push_expected(64'h0102_0408_1020_4080, 8'h3C, 8'h80);
    request(64'h0102_0408_1020_4080, 8'h3C, 3'd5, 1'b0);
    wait_idle();

    // Snapshot: inputs change and a request arrives mid-F2; neither takes effect.
    push_expected(64'hFEDC_BA98_7654_3210, 8'h0F, 8'h8A);
    request(64'hFEDC_BA98_7654_3210, 8'h0F, 3'd2, 1'b1);
    wait_bytes(5);
    @(negedge clk_50M);
    seg = 64'hFFFF_FFFF_FFFF_FFFF; led = 8'hF0; brightness = 3'd0; disp_on = 1'b0;
    upd_req = 1'b1;
    @(negedge clk_50M);
    upd_req = 1'b0;
    wait_idle();
    check("snapshot_drained", exp_q.size(), 0);

    // Asynchronous reset mid-F2 aborts the frame without done.
    push_expected(64'h7F7F_0000_AAAA_5555, 8'hC3, 8'h88);
    request(64'h7F7F_0000_AAAA_5555, 8'hC3, 3'd0, 1'b1);
    wait_bytes(8);
    repeat (3) @(posedge clk_50M);
    #3 reset = 1'b1;
    exp_q.delete();
    stbw_q.delete();
    exp_done--;
    #1;
    check("abort_stb", {31'd0, stb}, 1);
    check("abort_sclk", {31'd0, sclk}, 1);
    check("abort_dio", {31'd0, dio}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
    repeat (2) @(negedge clk_50M);
    push_expected(64'h7F7F_0000_AAAA_5555, 8'hC3, 8'h88);
    request(64'h7F7F_0000_AAAA_5555, 8'hC3, 3'd0, 1'b1);
    wait_idle();

    // Back-to-back: held request restarts after exactly one idle cycle.
    push_expected(64'h1122_3344_5566_7788, 8'h81, 8'h8B);
    push_expected(64'h1122_3344_5566_7788, 8'h81, 8'h8B);
    @(negedge clk_50M);
    seg = 64'h1122_3344_5566_7788; led = 8'h81; brightness = 3'd3; disp_on = 1'b1;
    upd_req = 1'b1;
    @(negedge clk_50M);
    begin
      int n = 0;
      while (busy && n < 4000) begin
        @(negedge clk_50M);
        n++;
      end
    end
    check("b2b_gap_idle", {31'd0, busy}, 0);
    @(negedge clk_50M);
    check("b2b_restart", {31'd0, busy}, 1);
    upd_req = 1'b0;
    seq_bytes = 0;
    wait_idle();

    // All LEDs requested: odd addresses stay 0x00 unless LED bytes are enabled.
    push_expected(64'h00FF_00FF_00FF_00FF, 8'hFF, 8'h8E);
    request(64'h00FF_00FF_00FF_00FF, 8'hFF, 3'd6, 1'b1);
    wait_idle();

    check("exp_q_drained", exp_q.size(), 0);
    check("stbw_q_drained", stbw_q.size(), 0);
    check("done_count", done_cnt, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
